// File: rtl/serial_slt_comparator.sv
// serial_slt_comparator
//   Bit-serial magnitude comparator for the ALU SLT/SLTU path. Captures two
//   operands and a signed/unsigned mode on an accepted start, then scans them
//   MSB-first, one bit per cycle, and reports less_than / equal with a
//   one-cycle done pulse.
//
//   Optional build macro: SERIAL_SLT_EARLY_EXIT_EN
//     defined   -> the scan stops on the first differing bit (variable latency)
//     undefined -> every compare takes WIDTH+1 cycles from start to done
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        compare request, accepted only in IDLE or DONE
//   signed_mode  1 = two's complement ordering, 0 = unsigned (captured with start)
//   a, b         operands (captured with start)
//   busy         high while the scan is running
//   done         one-cycle pulse when less_than / equal become valid
//   less_than    a < b under the captured mode, held until the next accepted start
//   equal        a == b, held until the next accepted start
module serial_slt_comparator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             less_than,
  output logic             equal
);

`ifdef SERIAL_SLT_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [CNT_W-1:0] IDX_MSB = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             lt_r_q, lt_r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             less_than_q, less_than_d;
  logic             equal_q, equal_d;

  // Bit under examination, picked with a one-hot mask so the index width
  // need not match log2(WIDTH).
  logic             a_bit, b_bit;
  logic             diff_now;
  logic             lt_now;

  assign a_bit    = |(a_q & (WIDTH'(1) << idx_q));
  assign b_bit    = |(b_q & (WIDTH'(1) << idx_q));
  assign diff_now = ~decided_q & (a_bit ^ b_bit);
  // At the sign bit a set bit means negative, hence smaller; elsewhere the
  // operand holding the 0 is the smaller one.
  assign lt_now   = ((idx_q == IDX_MSB) && signed_q) ? a_bit : ~a_bit;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      idx_q       <= '0;
      decided_q   <= 1'b0;
      lt_r_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      less_than_q <= 1'b0;
      equal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      idx_q       <= idx_d;
      decided_q   <= decided_d;
      lt_r_q      <= lt_r_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      less_than_q <= less_than_d;
      equal_q     <= equal_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    signed_d    = signed_q;
    idx_d       = idx_q;
    decided_d   = decided_q;
    lt_r_d      = lt_r_q;
    less_than_d = less_than_q;
    equal_d     = equal_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_COMPARE;
          a_d         = a;
          b_d         = b;
          signed_d    = signed_mode;
          idx_d       = IDX_MSB;
          decided_d   = 1'b0;
          lt_r_d      = 1'b0;
          less_than_d = 1'b0;
          equal_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_COMPARE: begin
        if (diff_now) begin
          decided_d = 1'b1;
          lt_r_d    = lt_now;
        end
        idx_d = idx_q - CNT_W'(1);
        if ((idx_q == '0) || (EARLY_EXIT && diff_now)) begin
          state_d     = S_DONE;
          less_than_d = diff_now ? lt_now : lt_r_q;
          equal_d     = ~(decided_q | diff_now);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flags are registered copies of the upcoming state, so they are mutually exclusive.
    busy_d = (state_d == S_COMPARE);
    done_d = (state_d == S_DONE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign less_than = less_than_q;
  assign equal     = equal_q;

endmodule

// File: tb/tb_serial_slt_comparator.sv
module tb_serial_slt_comparator;

  localparam int unsigned WIDTH = 32;
  localparam int FULL_LAT = 33;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             less_than;
  logic             equal;

  int n_tests = 0;
  int n_fail  = 0;

  serial_slt_comparator #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .less_than   (less_than),
    .equal       (equal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample #1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From cycle 1 of a compare, step until done; returns the cycle count.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  function automatic int exp_lat(input int lat_early);
`ifdef SERIAL_SLT_EARLY_EXIT_EN
    return lat_early;
`else
    return FULL_LAT + 0 * lat_early;
`endif
  endfunction

  // One complete compare. Operand inputs are scrambled after capture; when
  // poke is set a second start with other operands is issued mid-scan.
  task automatic do_cmp(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic mode, input logic exp_lt, input logic exp_eq,
                        input int lat_early, input bit poke);
    int cyc;
    @(negedge clk);
    a = va; b = vb; signed_mode = mode; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; signed_mode = ~mode;
    check({tag, "_busy1"}, 32'(busy), 32'd1);
    check({tag, "_lt_clr"}, 32'(less_than), 32'd0);
    if (poke) begin
      repeat (4) tick();
      a = vb; b = va; start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_poke"}, 32'(busy), 32'd1);
      wait_done(cyc);
      cyc = cyc + 5;
    end else begin
      wait_done(cyc);
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat(lat_early)));
    check({tag, "_lt"}, 32'(less_than), 32'(exp_lt));
    check({tag, "_eq"}, 32'(equal), 32'(exp_eq));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_lt_hold"}, 32'(less_than), 32'(exp_lt));
  endtask

  initial begin
    int cyc;
    int done_seen;
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lt", 32'(less_than), 32'd0);
    check("rst_eq", 32'(equal), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors: tag, a, b, mode, less_than, equal, early-exit latency
    do_cmp("t1_slt_neg1_vs_1",  32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 1'b0, 2,  1'b0);
    do_cmp("t2_sltu_max_vs_1",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 2,  1'b0);
    do_cmp("t3_eq_signed",      32'h1234ABCD, 32'h1234ABCD, 1'b1, 1'b0, 1'b1, 33, 1'b0);
    do_cmp("t3_eq_unsigned",    32'h1234ABCD, 32'h1234ABCD, 1'b0, 1'b0, 1'b1, 33, 1'b0);
    do_cmp("t4_msb_unsigned",   32'h00000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 2,  1'b0);
    do_cmp("t4b_msb_signed",    32'h00000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 2,  1'b0);
    do_cmp("min_vs_max_signed", 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 2,  1'b0);
    do_cmp("one_vs_neg1_signed",32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 2,  1'b0);
    do_cmp("lsb_only_lt",       32'h00000002, 32'h00000003, 1'b0, 1'b1, 1'b0, 33, 1'b0);
    do_cmp("ignored_start",     32'h00000003, 32'h00000002, 1'b0, 1'b0, 1'b0, 33, 1'b1);

    // Start, ignored start at cycle 10, reset at cycle 20
    @(negedge clk);
    a = 32'h1; b = 32'h0; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    a = 32'h0; b = 32'h1; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_busy_c10", 32'(busy), 32'd1);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_lt", 32'(less_than), 32'd0);
    check("t5_rst_eq", 32'(equal), 32'd0);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    check("t5_no_done", 32'(done_seen), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_lt", 32'(less_than), 32'd0);

    // Back-to-back: start held high through DONE
    @(negedge clk);
    a = 32'd5; b = 32'd7; signed_mode = 1'b0; start = 1'b1;
    tick();
    wait_done(cyc);
    check("t6_lat1", 32'(cyc), 32'(exp_lat(32)));
    check("t6_lt1", 32'(less_than), 32'd1);
    check("t6_busy_done", 32'(busy), 32'd0);
    a = 32'd7; b = 32'd5;
    tick();
    start = 1'b0;
    check("t6_busy2", 32'(busy), 32'd1);
    check("t6_done2_low", 32'(done), 32'd0);
    check("t6_lt_clr", 32'(less_than), 32'd0);
    wait_done(cyc);
    check("t6_gap", 32'(cyc), 32'(exp_lat(32)));
    check("t6_lt2", 32'(less_than), 32'd0);
    check("t6_eq2", 32'(equal), 32'd0);
    tick();
    check("t6_idle", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
